// File: rtl/secded_pkg.sv
// Shared types and layout helpers for the Hamming SECDED codec.
// The codeword puts overall parity at bit 0, Hamming parity at powers of two, and data everywhere else.
package secded_pkg;

  typedef enum logic {ENC = 1'b0, DEC = 1'b1} mode_e;

  typedef enum logic [1:0] {
    OK     = 2'b00,
    CORR   = 2'b01,
    UNCORR = 2'b10,
    P0ERR  = 2'b11
  } status_e;

  // Smallest r with 2**r >= data_w + r + 1.
  function automatic int parity_bits(input int data_w);
    int r;
    r = 0;
    for (int k = 15; k >= 1; k--)
      if ((1 << k) >= data_w + k + 1) r = k;
    return r;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position of data bit i (0-based); data fills non-power-of-two slots from bit 3 up.
  function automatic int data_pos(input int i);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int q = 3; q < 256; q++) begin
      if (!is_pow2(q)) begin
        if (n == i) pos = q;
        n++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of a codeword.
// With the parity slots zeroed, the syndrome bits are exactly the Hamming parity bits to insert.
module secded_syndrome #(
  parameter int CODE_W = 16,
  parameter int SYN_W  = 4
) (
  input  logic [CODE_W-1:0] i_word,
  output logic [SYN_W-1:0]  o_syn,
  output logic              o_par
);

  always_comb begin
    o_syn = '0;
    for (int p = 1; p < CODE_W; p++)
      if (i_word[p]) o_syn = o_syn ^ SYN_W'(p);
  end

  assign o_par = ^i_word;

endmodule

// File: rtl/secded_codec.sv
// Two-stage pipelined SECDED encoder/decoder with valid/ready handshake and saturating error counters.
// S1 captures the word with its syndrome and parity; S2 holds the encoded or corrected result.
module secded_codec
  import secded_pkg::*;
#(
  parameter  int DATA_W = 11,
  parameter  int CNT_W  = 8,
  localparam int R      = parity_bits(DATA_W),
  localparam int CODE_W = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CODE_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_word,
  output logic [1:0]        out_status,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic              r_vld_p1, r_vld_p2;
  mode_e             r_mode_p1;
  logic [CODE_W-1:0] r_word_p1, r_word_p2;
  logic [R-1:0]      r_syn_p1;
  logic              r_par_p1;
  status_e           r_status_p2;
  logic [CNT_W-1:0]  r_corr_cnt, r_uncorr_cnt;

  logic              w_s2_en, w_s1_en, w_s1_load, w_out_fire;
  logic [CODE_W-1:0] w_enc_map, w_syn_in, w_enc_word, w_fix, w_s2_word;
  logic [DATA_W-1:0] w_dec_data;
  logic [R-1:0]      w_syn;
  logic              w_par, w_do_flip;
  status_e           w_s2_status;

  assign w_s2_en    = !r_vld_p2 || out_ready;
  assign w_s1_en    = !r_vld_p1 || w_s2_en;
  assign in_ready   = w_s1_en;
  assign w_s1_load  = in_valid && w_s1_en;
  assign w_out_fire = r_vld_p2 && out_ready;

  // ---- S1: map data into codeword slots (encode) and compute syndrome/parity ----
  for (genvar g = 0; g < DATA_W; g++) begin : g_data
    assign w_enc_map[data_pos(g)]  = in_word[g];
    assign w_enc_word[data_pos(g)] = r_word_p1[data_pos(g)];
    assign w_dec_data[g]           = w_fix[data_pos(g)];
  end
  assign w_enc_map[0] = 1'b0;
  for (genvar k = 0; k < R; k++) begin : g_par
    assign w_enc_map[1 << k]  = 1'b0;
    assign w_enc_word[1 << k] = r_syn_p1[k];
  end
  // Overall parity covers the data (r_par_p1) plus the freshly inserted Hamming bits.
  assign w_enc_word[0] = r_par_p1 ^ (^r_syn_p1);

  assign w_syn_in = in_mode ? in_word : w_enc_map;

  secded_syndrome #(
    .CODE_W (CODE_W),
    .SYN_W  (R)
  ) u_syndrome (
    .i_word (w_syn_in),
    .o_syn  (w_syn),
    .o_par  (w_par)
  );

  always_ff @(posedge clk) begin
    if (reset) r_vld_p1 <= 1'b0;
    else if (w_s1_en) r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_s1_load) begin
      r_word_p1 <= w_syn_in;
      r_mode_p1 <= mode_e'(in_mode);
      r_syn_p1  <= w_syn;
      r_par_p1  <= w_par;
    end
  end

  // ---- S2: correct/classify decode words, finish encode words ----
  // A syndrome beyond the last codeword position cannot name a real bit in a shortened code.
  assign w_do_flip = r_par_p1 && (r_syn_p1 != '0) && (32'(r_syn_p1) < CODE_W);
  assign w_fix     = w_do_flip ? (r_word_p1 ^ (CODE_W'(1) << r_syn_p1)) : r_word_p1;

  always_comb begin
    w_s2_status = OK;
    w_s2_word   = w_enc_word;
    if (r_mode_p1 == DEC) begin
      w_s2_word = CODE_W'(w_dec_data);
      if (!r_par_p1)              w_s2_status = (r_syn_p1 == '0) ? OK : UNCORR;
      else if (r_syn_p1 == '0)    w_s2_status = P0ERR;
      else if (w_do_flip)         w_s2_status = CORR;
      else                        w_s2_status = UNCORR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p2    <= 1'b0;
      r_word_p2   <= '0;
      r_status_p2 <= OK;
    end else if (w_s2_en) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_word_p2   <= w_s2_word;
        r_status_p2 <= w_s2_status;
      end
    end
  end

  // ---- Output: counters advance on output transfer; clear wins over increment ----
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_out_fire) begin
      case (r_status_p2)
        CORR, P0ERR: r_corr_cnt   <= sat_inc(r_corr_cnt);
        UNCORR:      r_uncorr_cnt <= sat_inc(r_uncorr_cnt);
        default:     ;
      endcase
    end
  end

  assign out_valid  = r_vld_p2;
  assign out_word   = r_word_p2;
  assign out_status = r_status_p2;
  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;

endmodule
